// File: rtl/aes_pkg.sv
// Shared AES types, the GF(2^8) reduction constant and the xtime primitive.
// Also holds the FSM encoding for the iterative column-mix unit.
package aes_pkg;

   typedef logic [7:0]        aes_byte_t;
   typedef logic [3:0][7:0]   aes_col_t;
   typedef logic [15:0][7:0]  aes_state_t;

   localparam aes_byte_t AES_REDUCE = 8'h1B;

   typedef enum logic [1:0] {
      IMC_IDLE = 2'd0,
      IMC_BUSY = 2'd1,
      IMC_DONE = 2'd2
   } imc_fsm_e;

   // Multiply by 02 in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic aes_byte_t xtime(input aes_byte_t a);
      return {a[6:0], 1'b0} ^ (a[7] ? AES_REDUCE : 8'h00);
   endfunction

endpackage

// File: rtl/inv_mix_one_column.sv
// InvMixColumns of a single 4-byte column, purely combinational.
// Latency: none. Backpressure: not applicable.
module inv_mix_one_column
   import aes_pkg::*;
(
   input  aes_col_t col,
   output aes_col_t mixed
);

   aes_col_t x2, x4, x8;
   aes_col_t m9, mb, md, me;

   always_comb begin
      x2 = '0;
      x4 = '0;
      x8 = '0;
      m9 = '0;
      mb = '0;
      md = '0;
      me = '0;
      for (int i = 0; i < 4; i++) begin
         x2[i] = xtime(col[i]);
         x4[i] = xtime(x2[i]);
         x8[i] = xtime(x4[i]);
         m9[i] = x8[i] ^ col[i];
         mb[i] = x8[i] ^ x2[i] ^ col[i];
         md[i] = x8[i] ^ x4[i] ^ col[i];
         me[i] = x8[i] ^ x4[i] ^ x2[i];
      end
   end

   // Each output row is the circulant 0e,0b,0d,09 rotated by the row number.
   assign mixed[0] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
   assign mixed[1] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
   assign mixed[2] = md[0] ^ m9[1] ^ me[2] ^ mb[3];
   assign mixed[3] = mb[0] ^ md[1] ^ m9[2] ^ me[3];

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns: COLS_PER_CYCLE columns per clock on a local state register.
// Latency: out_valid rises 4/COLS_PER_CYCLE edges after acceptance.
// Backpressure: result held in DONE until out_ready; no new input accepted until handoff.
module inv_mix_columns_iter
   import aes_pkg::*;
#(
   parameter int COLS_PER_CYCLE = 1
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0][7:0] in_state,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0][7:0] out_state
);

   localparam logic [1:0] COL_STEP = 2'(COLS_PER_CYCLE);
   localparam logic [1:0] LAST_OFS = 2'(COLS_PER_CYCLE - 1);

   imc_fsm_e   fsm_q, fsm_d;
   logic [1:0] col_q, col_d;
   aes_state_t data_q, data_d;
   logic       out_valid_q;
   logic [1:0] last_col;

   logic [1:0] sel   [COLS_PER_CYCLE];
   aes_col_t   mixed [COLS_PER_CYCLE];

   genvar g;
   for (g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
      assign sel[g] = col_q + 2'(g);
      inv_mix_one_column u_mix (
         .col   (data_q[{sel[g], 2'b00} +: 4]),
         .mixed (mixed[g])
      );
   end

   // Highest column touched this cycle; reaching 3 finishes the state.
   assign last_col = col_q + LAST_OFS;

   always_comb begin
      fsm_d  = fsm_q;
      col_d  = col_q;
      data_d = data_q;
      case (fsm_q)
         IMC_IDLE: begin
            if (in_valid) begin
               data_d = in_state;
               col_d  = 2'd0;
               fsm_d  = IMC_BUSY;
            end
         end
         IMC_BUSY: begin
            for (int i = 0; i < COLS_PER_CYCLE; i++) begin
               data_d[{sel[i], 2'b00} +: 4] = mixed[i];
            end
            col_d = col_q + COL_STEP;
            if (last_col == 2'd3) begin
               col_d = 2'd0;
               fsm_d = IMC_DONE;
            end
         end
         IMC_DONE: begin
            if (out_ready) begin
               fsm_d = IMC_IDLE;
            end
         end
         default: fsm_d = IMC_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q       <= IMC_IDLE;
         col_q       <= 2'd0;
         data_q      <= '0;
         out_valid_q <= 1'b0;
      end else begin
         fsm_q       <= fsm_d;
         col_q       <= col_d;
         data_q      <= data_d;
         out_valid_q <= (fsm_d == IMC_DONE);
      end
   end

   assign in_ready  = (fsm_q == IMC_IDLE);
   assign out_valid = out_valid_q;
   assign out_state = data_q;

endmodule
